// File: rtl/div_seq_ctrl.sv
// Sequential radix-2 restoring divider: one trial subtract per clock, WIDTH iterations.
// Optional DIV_ZERO_TRAP_EN: a zero divisor finishes after a single cycle and raises dz.
module div_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dz
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_nxt;
  logic [WIDTH-1:0] r_a, r_q, r_d;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quo, r_rem;
  logic             w_accept, w_ge;
  logic [WIDTH:0]   w_ash;
  logic [WIDTH-1:0] w_t, w_an, w_qn;

  // The partial remainder always stays below D, so only the shifted trial
  // value needs the extra bit for the compare.
  assign w_accept = start && (r_state != S_RUN);
  assign w_ash    = {r_a, r_q[WIDTH-1]};
  assign w_ge     = w_ash >= {1'b0, r_d};
  assign w_t      = w_ash[WIDTH-1:0] - r_d;
  assign w_an     = w_ge ? w_t : w_ash[WIDTH-1:0];
  assign w_qn     = {r_q[WIDTH-2:0], w_ge};

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_nxt = w_accept ? S_RUN : S_IDLE;
      S_RUN:          if (r_cnt == '0) w_nxt = S_DONE;
      default:        w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_q   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
    end else if (w_accept) begin
      r_a <= '0;
      r_q <= num;
      r_d <= den;
`ifdef DIV_ZERO_TRAP_EN
      r_cnt <= (den == '0) ? '0 : CNT_W'(WIDTH-1);
`else
      r_cnt <= CNT_W'(WIDTH-1);
`endif
    end else if (r_state == S_RUN) begin
      r_a   <= w_an;
      r_q   <= w_qn;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
`ifdef DIV_ZERO_TRAP_EN
        // Trapped zero divisor: Q still holds the untouched dividend here.
        r_quo <= (r_d == '0) ? '1  : w_qn;
        r_rem <= (r_d == '0) ? r_q : w_an;
`else
        r_quo <= w_qn;
        r_rem <= w_an;
`endif
      end
    end
  end

`ifdef DIV_ZERO_TRAP_EN
  logic r_dz;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_dz <= 1'b0;
    else if (r_state == S_RUN && r_cnt == '0)  r_dz <= (r_d == '0);
  end
  assign dz = r_dz;
`else
  assign dz = 1'b0;
`endif

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign quo  = r_quo;
  assign rem  = r_rem;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: expected results queued at accept, checked at done.
module tb_div_seq_ctrl;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] num = '0, den = '0;
  logic       busy, done, dz;
  logic [7:0] quo, rem;

  typedef struct packed {logic [7:0] q; logic [7:0] r; logic z;} exp_t;
  exp_t sb[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, t0 = 0;

`ifdef DIV_ZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  div_seq_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .num(num), .den(den),
    .busy(busy), .done(done), .quo(quo), .rem(rem), .dz(dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mdl(input logic [7:0] n, input logic [7:0] d);
    exp_t e;
    if (d == 0) begin e.q = 8'hFF; e.r = n; e.z = TRAP; end
    else begin e.q = n / d; e.r = n % d; e.z = 1'b0; end
    return e;
  endfunction

  task automatic start_op(input logic [7:0] n, input logic [7:0] d);
    @(negedge clk);
    start = 1'b1; num = n; den = d;
    sb.push_back(mdl(n, d));
    @(negedge clk);
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_lat, input int exp_busy);
    int   nb = 0;
    exp_t e;
    while (!done && (cyc - t0) < 40) begin
      if (busy) nb++;
      @(negedge clk);
    end
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", nm, done, cyc - t0);
      return;
    end
    n_chk++;
    if (cyc - t0 != exp_lat) begin
      n_fail++; $display("FAIL %s_latency: got %0d, required %0d", nm, cyc - t0, exp_lat);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_in_done: got %b, required 0", nm, busy);
    end
    if (exp_busy >= 0) begin
      n_chk++;
      if (nb != exp_busy) begin
        n_fail++; $display("FAIL %s_busy_cycles: got %0d, required %0d", nm, nb, exp_busy);
      end
    end
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL %s_scoreboard: done with no expected entry", nm);
    end else begin
      e = sb.pop_front();
      if ({quo, rem, dz} !== {e.q, e.r, e.z}) begin
        n_fail++;
        $display("FAIL %s_result: got quo=%0d rem=%0d dz=%b, required quo=%0d rem=%0d dz=%b",
                 nm, quo, rem, dz, e.q, e.r, e.z);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if ({busy, done, quo, rem, dz} !== 19'd0) begin
      n_fail++; $display("FAIL reset_state: got busy=%b done=%b quo=%0d rem=%0d dz=%b, required all 0",
                         busy, done, quo, rem, dz);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    start_op(8'd200, 8'd7);
    wait_done("basic", 8, 8);
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_pulse: done=%b one cycle later, required 0", done);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if ({quo, rem} !== {8'd28, 8'd4}) begin
      n_fail++; $display("FAIL basic_hold: got quo=%0d rem=%0d, required 28/4", quo, rem);
    end
  endtask

  task automatic test_corners();
    logic [7:0] tn[4] = '{8'd255, 8'd5, 8'd0, 8'd255};
    logic [7:0] td[4] = '{8'd1,   8'd9, 8'd3, 8'd255};
    for (int i = 0; i < 4; i++) begin
      start_op(tn[i], td[i]);
      wait_done($sformatf("corner%0d", i), 8, 8);
    end
  endtask

  task automatic test_back_to_back();
    int td1;
    @(negedge clk);
    start = 1'b1; num = 8'd100; den = 8'd10;
    sb.push_back(mdl(8'd100, 8'd10));
    @(negedge clk);
    t0 = cyc;
    num = 8'd99;
    wait_done("b2b_first", 8, 8);
    td1 = cyc;
    sb.push_back(mdl(8'd99, 8'd10));
    @(negedge clk);
    t0 = cyc;
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept: busy=%b after done-cycle start, required 1", busy);
    end
    wait_done("b2b_second", 8, -1);
    n_chk++;
    if (cyc - td1 != 9) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d cycles, required 9", cyc - td1);
    end
  endtask

  task automatic test_ignored_start();
    start_op(8'd50, 8'd6);
    repeat (2) @(negedge clk);
    start = 1'b1; num = 8'd1; den = 8'd1;
    @(negedge clk);
    start = 1'b0; num = 8'd3; den = 8'd2;
    wait_done("ignored", 8, -1);
  endtask

  task automatic test_abort();
    bit saw_done = 1'b0;
    start_op(8'd200, 8'd7);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({busy, done, quo, rem, dz} !== 19'd0) begin
      n_fail++; $display("FAIL abort_async: got busy=%b done=%b quo=%0d rem=%0d dz=%b, required all 0",
                         busy, done, quo, rem, dz);
    end
    sb.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (i == 2) rst = 1'b0;
    end
    n_chk++;
    if (saw_done) begin
      n_fail++; $display("FAIL abort_no_done: got a done pulse after abort, required none");
    end
    start_op(8'd9, 8'd2);
    wait_done("after_abort", 8, 8);
  endtask

  task automatic test_div_zero();
    start_op(8'd77, 8'd0);
    wait_done("div_zero", TRAP ? 1 : 8, TRAP ? 1 : 8);
    start_op(8'd8, 8'd2);
    wait_done("after_div_zero", 8, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_ignored_start();
    test_abort();
    test_div_zero();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
